// File: rtl/rate_lockin.sv
`default_nettype none
// ============================================================================
//  Module   : rate_lockin
//  Purpose  : Measures the edge-to-edge interval of an already-synchronized
//             external clock, locks onto a stable half-period R and drives
//             the four rate words consumed by the downstream generation
//             stage. Also emits per-edge sync pulses and lock-health pulses.
//  Ports    : sys_dom_i            - clock (rising edge) + async active-high reset
//             lockin_en_i          - enable, low forces IDLE
//             sampled_clk_i        - synchronized external clock level
//             locked_o             - rate outputs valid
//             expected_half_rate_minus_two_o / expected_quarter_rate_minus_one_o
//             preemptive_half_rate_minus_one_o / preemptive_quarter_rate_minus_one_o
//             measured_interval_o  - last captured interval
//             sync_pulse_o         - one pulse per matching edge while locked
//             lockin_timeout_o     - one pulse when LOCKING runs out of edges
//             lost_lock_o          - one pulse when lock is dropped
//  Options  : CLKS_ALOT_MULTIPLE_RATE_EN - accept intervals near 2R/3R/4R as
//             matches while locked (like-bit runs on pausable data).
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef COMMON_P_PKG_DEFINED
`define COMMON_P_PKG_DEFINED
package common_p;
    typedef struct packed {
        logic clk;
        logic rst;
    } clk_dom_s;
endpackage
`endif

`ifndef CLKS_ALOT_P_PKG_DEFINED
`define CLKS_ALOT_P_PKG_DEFINED
package clks_alot_p;
    localparam int RATE_COUNTER_WIDTH = 16;
endpackage
`endif

module rate_lockin #(
    parameter int W               = clks_alot_p::RATE_COUNTER_WIDTH,
    parameter int LOCK_COUNT      = 4,
    parameter int DRIFT_TOLERANCE = 1,
    parameter int LOCK_TIMEOUT    = 64,
    parameter int MAX_MISMATCH    = 2,
    parameter int PREEMPT_CYCLES  = 2,
    parameter int MIN_HALF_RATE   = 4
) (
    input  common_p::clk_dom_s sys_dom_i,
    input  logic               lockin_en_i,
    input  logic               sampled_clk_i,
    output logic               locked_o,
    output logic [W-1:0]       expected_half_rate_minus_two_o,
    output logic [W-1:0]       expected_quarter_rate_minus_one_o,
    output logic [W-1:0]       preemptive_half_rate_minus_one_o,
    output logic [W-1:0]       preemptive_quarter_rate_minus_one_o,
    output logic [W-1:0]       measured_interval_o,
    output logic               sync_pulse_o,
    output logic               lockin_timeout_o,
    output logic               lost_lock_o
);

    // Extra headroom so that 4*R can be compared without wrapping.
    localparam int XW = W + 3;
    localparam int SW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(LOCK_TIMEOUT + 1);
    localparam int MW = $clog2(MAX_MISMATCH + 1);

    localparam logic [W-1:0]  c_sat          = '1;
    localparam logic [W-1:0]  c_min          = W'(MIN_HALF_RATE);
    localparam logic [XW-1:0] c_tol_x        = XW'(DRIFT_TOLERANCE);
    localparam logic [W-1:0]  c_two          = W'(2);
    localparam logic [W-1:0]  c_one          = W'(1);
    localparam logic [W-1:0]  c_pre_lead     = W'(1 + PREEMPT_CYCLES);
    localparam logic [SW-1:0] c_lock_count   = SW'(LOCK_COUNT);
    localparam logic [EW-1:0] c_timeout_last = EW'(LOCK_TIMEOUT - 1);
    localparam logic [MW-1:0] c_mm_last      = MW'(MAX_MISMATCH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_LOCKING = 2'd2,
        S_LOCKED  = 2'd3
    } state_t;

    logic clk;
    logic rst;
    assign clk = sys_dom_i.clk;
    assign rst = sys_dom_i.rst;

    state_t        r_state;
    logic          r_prev;
    logic [W-1:0]  r_cnt;
    logic [W-1:0]  r_cand;
    logic [W-1:0]  r_rate;
    logic [SW-1:0] r_streak;
    logic [EW-1:0] r_edge_cnt;
    logic [MW-1:0] r_mismatch;

    function automatic logic [XW-1:0] abs_diff(input logic [XW-1:0] a,
                                               input logic [XW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [W-1:0] clamp_sub(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        return (a >= b) ? (a - b) : '0;
    endfunction

    // Edge detect on both polarities.
    logic w_edge;
    assign w_edge = (sampled_clk_i != r_prev);

    // A saturated count means the real interval is unknown.
    logic w_valid;
    logic w_usable;
    assign w_valid  = (r_cnt != c_sat);
    assign w_usable = w_valid && (r_cnt >= c_min);

    logic [XW-1:0] w_cnt_x;
    logic [XW-1:0] w_cand_x;
    logic [XW-1:0] w_rate_x;
    assign w_cnt_x  = {3'b000, r_cnt};
    assign w_cand_x = {3'b000, r_cand};
    assign w_rate_x = {3'b000, r_rate};

    logic w_cand_match;
    assign w_cand_match = (abs_diff(w_cnt_x, w_cand_x) <= c_tol_x);

    // Match test while locked; R itself never moves inside the window.
    logic w_rate_match;
`ifdef CLKS_ALOT_MULTIPLE_RATE_EN
    logic [XW-1:0] w_rate_x2;
    logic [XW-1:0] w_rate_x3;
    logic [XW-1:0] w_rate_x4;
    assign w_rate_x2 = w_rate_x << 1;
    assign w_rate_x3 = w_rate_x2 + w_rate_x;
    assign w_rate_x4 = w_rate_x << 2;
    assign w_rate_match = w_valid &&
                          ((abs_diff(w_cnt_x, w_rate_x)  <= c_tol_x) ||
                           (abs_diff(w_cnt_x, w_rate_x2) <= c_tol_x) ||
                           (abs_diff(w_cnt_x, w_rate_x3) <= c_tol_x) ||
                           (abs_diff(w_cnt_x, w_rate_x4) <= c_tol_x));
`else
    assign w_rate_match = w_valid && (abs_diff(w_cnt_x, w_rate_x) <= c_tol_x);
`endif

    // Candidate/streak update for an edge seen in LOCKING.
    logic [W-1:0]  w_next_cand;
    logic [SW-1:0] w_next_streak;
    always_comb begin
        w_next_cand   = r_cand;
        w_next_streak = r_streak;
        if (!w_usable) begin
            w_next_streak = '0;
        end else if ((r_streak == '0) || !w_cand_match) begin
            w_next_cand   = r_cnt;
            w_next_streak = SW'(1);
        end else begin
            w_next_streak = r_streak + 1'b1;
        end
    end

    logic w_lock_now;
    assign w_lock_now = (w_next_streak == c_lock_count);

    // Rate words derived from the candidate that is about to become R.
    logic [W-1:0] w_cand_half;
    logic [W-1:0] w_half_two;
    logic [W-1:0] w_quarter_one;
    logic [W-1:0] w_pre_half;
    logic [W-1:0] w_pre_quarter;
    assign w_cand_half   = w_next_cand >> 1;
    assign w_half_two    = clamp_sub(w_next_cand, c_two);
    assign w_quarter_one = clamp_sub(w_cand_half, c_one);
    assign w_pre_half    = clamp_sub(w_next_cand, c_pre_lead);
    assign w_pre_quarter = clamp_sub(w_cand_half, c_pre_lead);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state                             <= S_IDLE;
            r_prev                              <= 1'b0;
            r_cnt                               <= '0;
            r_cand                              <= '0;
            r_rate                              <= '0;
            r_streak                            <= '0;
            r_edge_cnt                          <= '0;
            r_mismatch                          <= '0;
            locked_o                            <= 1'b0;
            expected_half_rate_minus_two_o      <= '0;
            expected_quarter_rate_minus_one_o   <= '0;
            preemptive_half_rate_minus_one_o    <= '0;
            preemptive_quarter_rate_minus_one_o <= '0;
            measured_interval_o                 <= '0;
            sync_pulse_o                        <= 1'b0;
            lockin_timeout_o                    <= 1'b0;
            lost_lock_o                         <= 1'b0;
        end else begin
            r_prev           <= sampled_clk_i;
            sync_pulse_o     <= 1'b0;
            lockin_timeout_o <= 1'b0;
            lost_lock_o      <= 1'b0;

            if (!lockin_en_i) begin
                // Disable wins over any edge in flight: no pulses, counters clear.
                r_state    <= S_IDLE;
                locked_o   <= 1'b0;
                r_cnt      <= '0;
                r_streak   <= '0;
                r_edge_cnt <= '0;
                r_mismatch <= '0;
            end else begin
                if (r_state != S_IDLE) begin
                    if (w_edge) begin
                        r_cnt <= W'(1);
                    end else if (r_cnt != c_sat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                case (r_state)
                    S_IDLE: begin
                        r_state <= S_ARMED;
                    end

                    S_ARMED: begin
                        // First edge only starts the interval counter.
                        if (w_edge) begin
                            r_state    <= S_LOCKING;
                            r_streak   <= '0;
                            r_edge_cnt <= '0;
                        end
                    end

                    S_LOCKING: begin
                        if (w_edge) begin
                            measured_interval_o <= r_cnt;
                            r_cand              <= w_next_cand;
                            r_streak            <= w_next_streak;
                            if (w_lock_now) begin
                                // Locking takes precedence over a coincident timeout.
                                r_state    <= S_LOCKED;
                                locked_o   <= 1'b1;
                                r_rate     <= w_next_cand;
                                r_mismatch <= '0;
                                r_edge_cnt <= '0;
                                expected_half_rate_minus_two_o      <= w_half_two;
                                expected_quarter_rate_minus_one_o   <= w_quarter_one;
                                preemptive_half_rate_minus_one_o    <= w_pre_half;
                                preemptive_quarter_rate_minus_one_o <= w_pre_quarter;
                            end else if (r_edge_cnt == c_timeout_last) begin
                                lockin_timeout_o <= 1'b1;
                                r_edge_cnt       <= '0;
                            end else begin
                                r_edge_cnt <= r_edge_cnt + 1'b1;
                            end
                        end
                    end

                    S_LOCKED: begin
                        if (w_edge) begin
                            measured_interval_o <= r_cnt;
                            if (w_rate_match) begin
                                sync_pulse_o <= 1'b1;
                                r_mismatch   <= '0;
                            end else if (r_mismatch == c_mm_last) begin
                                // Restart acquisition seeded with the offending interval.
                                lost_lock_o <= 1'b1;
                                locked_o    <= 1'b0;
                                r_state     <= S_LOCKING;
                                r_cand      <= r_cnt;
                                r_streak    <= w_usable ? SW'(1) : '0;
                                r_edge_cnt  <= '0;
                                r_mismatch  <= '0;
                            end else begin
                                r_mismatch <= r_mismatch + 1'b1;
                            end
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
